// File: rtl/uart_pkg.sv
// Shared types and constants for the fabric UART receive path.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Number of system clocks per serial bit (integer division, truncating).
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush, level and full flags.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;

  // A pop only happens with data present; a push into a full FIFO only
  // succeeds when a pop frees a slot in the same cycle; flush kills the push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop) && !clear;

  // Head byte falls through; forced to zero while empty so it is never X.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage array, data only, no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo_bridge.sv
// 8N1 UART receiver feeding a FWFT byte FIFO exposed as a valid/ready stream.
module uart_rx_fifo_bridge
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 40000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            uart_rxd_i,
  input  logic                            clear_i,
  output logic [7:0]                      rx_data_o,
  output logic                            rx_valid_o,
  input  logic                            rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o,
  output logic                            frame_err_o,
  output logic                            overflow_o
);

  localparam int          CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [15:0] CNT_HALF     = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] CNT_FULL     = 16'(CLKS_PER_BIT - 1);
  localparam int          IW           = $clog2(DATA_BITS);

  logic                 rxd_p0;
  logic                 rxd_s;
  rx_state_e            state_q, state_nxt;
  logic [15:0]          cnt_q, cnt_nxt;
  logic [IW-1:0]        idx_q, idx_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic                 push_q, push_nxt;
  logic                 ferr_q, ferr_nxt;
  logic                 overflow_q;
  logic                 sample;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;

  assign sample = (cnt_q == 16'd0);

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rxd_p0 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      rxd_p0 <= uart_rxd_i;
      rxd_s  <= rxd_p0;
    end
  end

  // Receiver control state: FSM, bit timer, bit index, push and error strobes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      push_q  <= push_nxt;
      ferr_q  <= ferr_nxt;
    end
  end

  // Deserialising shift register, data only.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_nxt;
  end

  // Next-state logic: sample mid-bit, LSB first, check stop, wait out breaks.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    shift_nxt = shift_q;
    push_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_nxt = START;
          cnt_nxt   = CNT_HALF;
        end
      end
      START: begin
        if (!sample) begin
          cnt_nxt = cnt_q - 16'd1;
        end else if (rxd_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DATA;
          cnt_nxt   = CNT_FULL;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (!sample) begin
          cnt_nxt = cnt_q - 16'd1;
        end else begin
          shift_nxt = {rxd_s, shift_q[DATA_BITS-1:1]};
          cnt_nxt   = CNT_FULL;
          if (idx_q == IW'(DATA_BITS - 1)) state_nxt = STOP;
          else                             idx_nxt   = idx_q + IW'(1);
        end
      end
      STOP: begin
        if (!sample) begin
          cnt_nxt = cnt_q - 16'd1;
        end else if (rxd_s) begin
          push_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          ferr_nxt  = 1'b1;
          state_nxt = BREAK;
        end
      end
      BREAK: begin
        if (rxd_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop = rx_valid_o && rx_ready_i;

  // Sticky overflow: a byte arrived while full and no slot was freed.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                           overflow_q <= 1'b0;
    else if (clear_i)                         overflow_q <= 1'b0;
    else if (push_q && fifo_full && !pop)     overflow_q <= 1'b1;
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (reset_n_i),
    .clear     (clear_i),
    .push      (push_q),
    .push_data (shift_q),
    .pop       (pop),
    .pop_data  (rx_data_o),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level_o)
  );

  assign rx_valid_o  = !fifo_empty;
  assign frame_err_o = ferr_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo_bridge.sv
// Directed bench for uart_rx_fifo_bridge at 10 clocks per bit, 4-entry FIFO.
module tb_uart_rx_fifo_bridge;
  import uart_pkg::*;

  logic       clk_i;
  logic       reset_n_i;
  logic       uart_rxd_i;
  logic       clear_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;
  logic [2:0] fifo_level_o;
  logic       frame_err_o;
  logic       overflow_o;

  int         total;
  int         bad;
  logic [7:0] got[$];
  int         ferr_cnt;
  int         vld_cnt;

  uart_rx_fifo_bridge #(
    .CLK_FREQ   (1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .uart_rxd_i   (uart_rxd_i),
    .clear_i      (clear_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .fifo_level_o (fifo_level_o),
    .frame_err_o  (frame_err_o),
    .overflow_o   (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Observe the stream on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      if (rx_valid_o && rx_ready_i) got.push_back(rx_data_o);
      if (frame_err_o) ferr_cnt++;
      if (rx_valid_o) vld_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic reset_mon();
    got.delete();
    ferr_cnt = 0;
    vld_cnt  = 0;
  endtask

  // One 8N1 frame, 10 clocks per bit; the line is left at the stop value.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd_i = 1'b0;
    wait_cyc(10);
    for (int i = 0; i < 8; i++) begin
      uart_rxd_i = b[i];
      wait_cyc(10);
    end
    uart_rxd_i = stop;
    wait_cyc(10);
  endtask

  initial begin
    logic [7:0] mid;
    total      = 0;
    bad        = 0;
    ferr_cnt   = 0;
    vld_cnt    = 0;
    reset_n_i  = 1'b0;
    uart_rxd_i = 1'b1;
    clear_i    = 1'b0;
    rx_ready_i = 1'b0;
    wait_cyc(3);
    check("rst_data",  32'(rx_data_o),    32'h0);
    check("rst_valid", 32'(rx_valid_o),   32'h0);
    check("rst_level", 32'(fifo_level_o), 32'h0);
    check("rst_ferr",  32'(frame_err_o),  32'h0);
    check("rst_ovf",   32'(overflow_o),   32'h0);
    reset_n_i = 1'b1;
    wait_cyc(10);

    // Single byte straight through.
    rx_ready_i = 1'b1;
    reset_mon();
    send_byte(8'hA5, 1'b1);
    wait_cyc(20);
    check("a5_count", 32'(got.size()),   32'd1);
    check("a5_data",  32'(got[0]),       32'hA5);
    check("a5_vld1",  32'(vld_cnt),      32'd1);
    check("a5_level", 32'(fifo_level_o), 32'd0);
    check("a5_ferr",  32'(ferr_cnt),     32'd0);

    // Short low glitch is rejected at the start-bit sample.
    reset_mon();
    uart_rxd_i = 1'b0;
    wait_cyc(3);
    uart_rxd_i = 1'b1;
    wait_cyc(30);
    check("gl_count", 32'(got.size()),   32'd0);
    check("gl_ferr",  32'(ferr_cnt),     32'd0);
    check("gl_level", 32'(fifo_level_o), 32'd0);
    check("gl_idle",  32'(dut.state_q),  32'(IDLE));

    // Bad stop bit followed by a held-low break, then a good frame.
    reset_mon();
    send_byte(8'h3C, 1'b0);
    wait_cyc(50);
    uart_rxd_i = 1'b1;
    wait_cyc(20);
    check("brk_ferr1", 32'(ferr_cnt),     32'd1);
    check("brk_level", 32'(fifo_level_o), 32'd0);
    check("brk_none",  32'(got.size()),   32'd0);
    check("brk_novld", 32'(vld_cnt),      32'd0);
    send_byte(8'h81, 1'b1);
    wait_cyc(20);
    check("brk_next_cnt", 32'(got.size()), 32'd1);
    check("brk_next",     32'(got[0]),     32'h81);
    check("brk_ferr_end", 32'(ferr_cnt),   32'd1);

    // Overflow: five bytes into four slots with the consumer stalled.
    rx_ready_i = 1'b0;
    reset_mon();
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1);
      wait_cyc(2);
    end
    wait_cyc(5);
    check("ovf_level", 32'(fifo_level_o), 32'd4);
    check("ovf_flag",  32'(overflow_o),   32'd1);
    check("ovf_valid", 32'(rx_valid_o),   32'd1);
    check("ovf_head",  32'(rx_data_o),    32'h01);
    rx_ready_i = 1'b1;
    wait_cyc(8);
    rx_ready_i = 1'b0;
    check("ovf_drain_cnt", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("ovf_drain%0d", i), 32'(got[i]), 32'(i + 1));
    check("ovf_level0", 32'(fifo_level_o), 32'd0);
    check("ovf_sticky", 32'(overflow_o),   32'd1);
    clear_i = 1'b1;
    wait_cyc(1);
    clear_i = 1'b0;
    check("clr_ovf", 32'(overflow_o), 32'd0);

    // Full FIFO with a pop in the same cycle as the push of 0x77.
    reset_mon();
    send_byte(8'h11, 1'b1); wait_cyc(2);
    send_byte(8'h22, 1'b1); wait_cyc(2);
    send_byte(8'h33, 1'b1); wait_cyc(2);
    send_byte(8'h44, 1'b1); wait_cyc(2);
    check("full_level", 32'(fifo_level_o), 32'd4);
    check("full_ovf",   32'(overflow_o),   32'd0);
    fork
      send_byte(8'h77, 1'b1);
      begin
        wait_cyc(98);
        rx_ready_i = 1'b1;
        wait_cyc(1);
        rx_ready_i = 1'b0;
      end
    join
    wait_cyc(2);
    check("pp_ovf",   32'(overflow_o),   32'd0);
    check("pp_level", 32'(fifo_level_o), 32'd4);
    check("pp_pop",   32'(got.size()),   32'd1);
    rx_ready_i = 1'b1;
    wait_cyc(8);
    check("pp_total", 32'(got.size()),   32'd5);
    check("pp_first", 32'(got[0]),       32'h11);
    check("pp_last",  32'(got[4]),       32'h77);
    check("pp_empty", 32'(fifo_level_o), 32'd0);

    // Reset during data bit 4 with a byte already buffered.
    rx_ready_i = 1'b0;
    reset_mon();
    send_byte(8'h99, 1'b1);
    wait_cyc(5);
    check("pre_rst_level", 32'(fifo_level_o), 32'd1);
    mid = 8'hC3;
    uart_rxd_i = 1'b0;
    wait_cyc(10);
    for (int i = 0; i < 4; i++) begin
      uart_rxd_i = mid[i];
      wait_cyc(10);
    end
    uart_rxd_i = mid[4];
    wait_cyc(4);
    reset_n_i = 1'b0;
    wait_cyc(1);
    check("mid_rst_data",  32'(rx_data_o),    32'h0);
    check("mid_rst_valid", 32'(rx_valid_o),   32'h0);
    check("mid_rst_level", 32'(fifo_level_o), 32'h0);
    check("mid_rst_ferr",  32'(frame_err_o),  32'h0);
    check("mid_rst_ovf",   32'(overflow_o),   32'h0);
    uart_rxd_i = 1'b1;
    wait_cyc(3);
    reset_n_i = 1'b1;
    wait_cyc(10);
    reset_mon();
    rx_ready_i = 1'b1;
    send_byte(8'h5A, 1'b1);
    wait_cyc(20);
    check("post_rst_cnt",  32'(got.size()), 32'd1);
    check("post_rst_data", 32'(got[0]),     32'h5A);
    check("post_rst_ferr", 32'(ferr_cnt),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
